// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path: segment patterns,
// FSM state encodings and the double-dabble step helper.
package score_display_pkg;

    localparam int SCORE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low patterns, bit order {dp,g,f,e,d,c,b,a}; dp held off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5) begin
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
            end else begin
                a[8+4*i +: 4] = a[8+4*i +: 4];
            end
        end
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern, with forced blank.
import score_display_pkg::*;

module seg7_decode (
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Pattern lookup; non-decimal codes and blanked digits show nothing.
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Score to 3-digit multiplexed 7-segment display: serial double-dabble plus scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
import score_display_pkg::*;

module score_display #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   score,
    input  logic         score_valid,
    output logic         busy,
    output logic [11:0]  bcd,
    output logic         bcd_valid,
    output logic [3:0]   an,
    output logic [7:0]   seg
);

    state_t             r_state, w_state_nxt;
    logic [19:0]        r_shift, w_shift_nxt;
    logic [3:0]         r_bitcnt, w_bitcnt_nxt;
    logic               r_pend_vld, w_pend_vld_nxt;
    logic [7:0]         r_pend, w_pend_nxt;
    logic [11:0]        r_bcd;
    logic               r_bcd_valid, r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_an, w_an_nxt, w_digit;
    logic [7:0]         r_seg, w_seg;
    logic               w_blank;

    // Conversion FSM next-state; strobes arriving while busy park in the pending slot.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bitcnt_nxt   = r_bitcnt;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        case (r_state)
            ST_IDLE: begin
                if (score_valid) begin
                    w_shift_nxt    = {12'h000, score};
                    w_bitcnt_nxt   = 4'd0;
                    w_pend_vld_nxt = 1'b0;
                    w_state_nxt    = ST_SHIFT;
                end else if (r_pend_vld) begin
                    w_shift_nxt    = {12'h000, r_pend};
                    w_bitcnt_nxt   = 4'd0;
                    w_pend_vld_nxt = 1'b0;
                    w_state_nxt    = ST_SHIFT;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_shift_nxt  = dabble_step(r_shift);
                w_bitcnt_nxt = r_bitcnt + 4'd1;
                if (r_bitcnt == 4'd7) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
                if (score_valid) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_nxt     = score;
                end else begin
                    w_pend_vld_nxt = r_pend_vld;
                end
            end
            ST_DONE: begin
                if (r_pend_vld) begin
                    w_shift_nxt    = {12'h000, r_pend};
                    w_bitcnt_nxt   = 4'd0;
                    w_state_nxt    = ST_SHIFT;
                    w_pend_vld_nxt = score_valid;
                    w_pend_nxt     = score_valid ? score : r_pend;
                end else begin
                    w_state_nxt = ST_IDLE;
                    if (score_valid) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_nxt     = score;
                    end else begin
                        w_pend_vld_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_pend_vld_nxt = 1'b0;
            end
        endcase
    end

    // Conversion state, result capture and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= 20'h00000;
            r_bitcnt    <= 4'd0;
            r_pend_vld  <= 1'b0;
            r_pend      <= 8'h00;
            r_bcd       <= 12'h000;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend      <= w_pend_nxt;
            r_bcd       <= (r_state == ST_DONE) ? r_shift[19:8] : r_bcd;
            r_bcd_valid <= (r_state == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Digit selection and leading-zero policy for the digit about to be refreshed.
    always_comb begin
        w_digit  = r_bcd[3:0];
        w_blank  = 1'b0;
        w_an_nxt = 4'b1111;
        case (r_idx)
            2'd0: begin
                w_digit  = r_bcd[3:0];
                w_an_nxt = 4'b1110;
            end
            2'd1: begin
                w_digit  = r_bcd[7:4];
                w_an_nxt = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank  = (r_bcd[11:4] == 8'h00);
`else
                w_blank  = 1'b0;
`endif
            end
            2'd2: begin
                w_digit  = r_bcd[11:8];
                w_an_nxt = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank  = (r_bcd[11:8] == 4'h0);
`else
                w_blank  = 1'b0;
`endif
            end
            default: begin
                w_digit  = r_bcd[3:0];
                w_an_nxt = 4'b1111;
            end
        endcase
    end

    seg7_decode u_decode (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    // Scan divider; an/seg load together at the start of each digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_cnt <= '0;
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (r_cnt == '0) begin
                r_an  <= w_an_nxt;
                r_seg <= w_seg;
            end else begin
                r_an  <= r_an;
                r_seg <= r_seg;
            end
        end
    end

    assign busy      = r_busy;
    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule
